gf_vme_access_ctrl: RTL and testbench
=====================================

Name: gf_vme_access_ctrl

Overview:
VME A24/D32 slave-cycle sequencer for the gigafitter board register space. It synchronises the asynchronous VME strobes, checks the board base address, latches the 16-bit local address and the write data, and drives the level-type writeAccess/readAccess lines that are shared by all per-register RW pulse decoders. It closes each cycle with DTACK (on success) or BERR (on read timeout), and it guarantees the access lines drop between cycles so the decoders' vetoes re-arm.

Parameters:
BASE_ADDR, 8'h00, board select value compared against vme_addr[23:16]
SYNC_STAGES, 2, synchroniser depth on as/ds/write strobes (minimum 2)
WR_HOLD, 3, cycles writeAccess is held before DTACK is asserted (minimum 2)
RD_TIMEOUT, 255, read-wait cycles before BERR (minimum 1, maximum 65535)

Ports:
clk  in  1  system clock
init_n  in  1  synchronous active-low reset
vme_as_n  in  1  VME address strobe, asynchronous
vme_ds_n  in  1  VME data strobe (DS0 & DS1 combined), asynchronous
vme_write_n  in  1  VME write line, asynchronous, 0 = write
vme_addr  in  24  VME address, stable while AS is low
vme_data_in  in  32  VME write data, stable while DS is low
rd_valid  in  1  register block read data valid
rd_data  in  32  register block read data
address  out  16  latched local address, goes to the decoders
wr_data  out  32  latched write data
writeAccess  out  1  write access level to the decoders
readAccess  out  1  read access level to the decoders
vme_data_out  out  32  registered read data
data_oe  out  1  VME data buffer output enable (read ACK only)
dtack_n  out  1  VME DTACK, active low
berr_n  out  1  VME BERR, active low

Behaviour:
- Every output is registered. Reset is sampled only on a clk edge with init_n low. Reset values: address=0, wr_data=0, vme_data_out=0, writeAccess=0, readAccess=0, data_oe=0, dtack_n=1, berr_n=1, state=IDLE, counter=0, all synchroniser flops=1.
- as_s, ds_s and wr_s are the SYNC_STAGES-deep synchronised strobes. vme_addr and vme_data_in are not synchronised; they are sampled only on the IDLE exit edge.
- The cycle counter has width clog2(max(WR_HOLD, RD_TIMEOUT)+1) and saturates; it never wraps.
- States: IDLE, WRITE, READ, ACK, BERR, IGNORE, RELEASE.
- IDLE, when as_s=0 and ds_s=0:
  - If vme_addr[23:16]==BASE_ADDR: latch address←vme_addr[15:0] and clear the counter. If wr_s=0, latch wr_data←vme_data_in, set writeAccess=1 and go to WRITE. Otherwise set readAccess=1 and go to READ.
  - If the base address does not match, go to IGNORE.
- WRITE: counter increments each cycle. When counter==WR_HOLD-1, set dtack_n=0 and go to ACK. Result: writeAccess rises at edge N and dtack_n falls at edge N+WR_HOLD.
- READ:
  - If rd_valid=1: vme_data_out←rd_data, dtack_n=0, data_oe=1, go to ACK. rd_valid wins if it coincides with timeout.
  - Else if counter==RD_TIMEOUT-1: berr_n=0, go to BERR.
  - rd_valid seen in the same cycle readAccess first rises is accepted.
- ACK/BERR: access line stays asserted, which holds the decoder veto and prevents a second pulse. The block waits for ds_s=1, then deasserts dtack_n, berr_n, data_oe, writeAccess and readAccess, and goes to RELEASE.
- IGNORE: no outputs change. Wait for as_s=1, then go to IDLE.
- RELEASE: wait for as_s=1, then go to IDLE. This guarantees at least one cycle with both access lines low between cycles. Address-pipelined and block transfers (AS held low across DS cycles) are not supported.
- Master abort: if as_s=1 while in WRITE or READ, deassert everything and go to IDLE on the next edge with no DTACK or BERR. The decoder pulse may already have fired; this is acceptable.
- readAccess and writeAccess are never high simultaneously. dtack_n and berr_n are never low simultaneously.
- A reset edge in any state forces the reset values in the same edge, including mid-ACK (DTACK is released immediately).

Test Plan:
- Write, BASE_ADDR=8'h20, WR_HOLD=3: vme_addr=24'h200104, data=32'hDEADBEEF, AS/DS/WRITE low → address=16'h0104 and wr_data=DEADBEEF with writeAccess high at edge N; dtack_n low at N+3; after DS high, all lines release within SYNC_STAGES+1 cycles; writeAccess low ≥1 cycle before the next cycle is accepted.
- Read: rd_valid with rd_data=32'h12345678 asserted 3 cycles after readAccess rises → vme_data_out=12345678, data_oe=1 and dtack_n=0 on the next edge; readAccess held until DS high.
- Read timeout, RD_TIMEOUT=8: rd_valid never asserted → berr_n low exactly 8 cycles after readAccess rises; dtack_n stays 1; BERR clears after DS high.
- Unselected: vme_addr=24'h300000 with BASE_ADDR=8'h20 → no access line, dtack_n or berr_n activity; the next selected cycle after AS high succeeds.
- Abort and reset: AS released mid-READ → IDLE, no DTACK. Separately, init_n low for one edge during ACK → dtack_n=1, readAccess=0, state IDLE on that edge.
- Coincidence: rd_valid asserted on the timeout cycle → DTACK with data, no BERR.

Source files
------------

// File: rtl/gf_vme_access_ctrl.sv
// VME A24/D32 slave-cycle sequencer for the gigafitter register space.
// Synchronises VME strobes, drives the shared read/write access levels, closes cycles with DTACK/BERR.
module gf_vme_access_ctrl #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WR_HOLD     = 3,
  parameter int unsigned RD_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        vme_as_n,
  input  logic        vme_ds_n,
  input  logic        vme_write_n,
  input  logic [23:0] vme_addr,
  input  logic [31:0] vme_data_in,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic [15:0] address,
  output logic [31:0] wr_data,
  output logic        writeAccess,
  output logic        readAccess,
  output logic [31:0] vme_data_out,
  output logic        data_oe,
  output logic        dtack_n,
  output logic        berr_n
);

  localparam int unsigned MaxCnt = (WR_HOLD > RD_TIMEOUT) ? WR_HOLD : RD_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] WrLast = CntW'(WR_HOLD - 1);
  localparam logic [CntW-1:0] RdLast = CntW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StWrite, StRead, StAck, StBerr, StIgnore, StRelease
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SYNC_STAGES-1:0] as_sync_q, ds_sync_q, wr_sync_q;
  logic as_s, ds_s, wr_s;

  logic [15:0] address_q, address_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        oe_q, oe_d;
  logic        dtack_q, dtack_d;
  logic        berr_q, berr_d;

  assign as_s = as_sync_q[SYNC_STAGES-1];
  assign ds_s = ds_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];

  // Saturating count so a stuck cycle can never wrap back into a valid compare.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!init_n) begin
      as_sync_q <= '1;
      ds_sync_q <= '1;
      wr_sync_q <= '1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      address_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      oe_q      <= 1'b0;
      dtack_q   <= 1'b1;
      berr_q    <= 1'b1;
    end else begin
      as_sync_q <= {as_sync_q[SYNC_STAGES-2:0], vme_as_n};
      ds_sync_q <= {ds_sync_q[SYNC_STAGES-2:0], vme_ds_n};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], vme_write_n};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      write_q   <= write_d;
      read_q    <= read_d;
      oe_q      <= oe_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    read_d    = read_q;
    oe_d      = oe_q;
    dtack_d   = dtack_q;
    berr_d    = berr_q;
    case (state_q)
      StIdle: begin
        if (!as_s && !ds_s) begin
          if (vme_addr[23:16] == BASE_ADDR) begin
            address_d = vme_addr[15:0];
            cnt_d     = '0;
            if (!wr_s) begin
              wr_data_d = vme_data_in;
              write_d   = 1'b1;
              state_d   = StWrite;
            end else begin
              read_d  = 1'b1;
              state_d = StRead;
            end
          end else begin
            state_d = StIgnore;
          end
        end
      end
      StWrite: begin
        if (as_s) begin
          write_d = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == WrLast) begin
            dtack_d = 1'b0;
            state_d = StAck;
          end
        end
      end
      StRead: begin
        if (as_s) begin
          read_d  = 1'b0;
          state_d = StIdle;
        end else if (rd_valid) begin
          rdata_d = rd_data;
          dtack_d = 1'b0;
          oe_d    = 1'b1;
          state_d = StAck;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == RdLast) begin
            berr_d  = 1'b0;
            state_d = StBerr;
          end
        end
      end
      // Access level stays up until DS rises so the decoder veto cannot re-fire.
      StAck, StBerr: begin
        if (ds_s) begin
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          oe_d    = 1'b0;
          write_d = 1'b0;
          read_d  = 1'b0;
          state_d = StRelease;
        end
      end
      StIgnore, StRelease: begin
        if (as_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign address      = address_q;
  assign wr_data      = wr_data_q;
  assign writeAccess  = write_q;
  assign readAccess   = read_q;
  assign vme_data_out = rdata_q;
  assign data_oe      = oe_q;
  assign dtack_n      = dtack_q;
  assign berr_n       = berr_q;

endmodule

// File: tb/tb_gf_vme_access_ctrl.sv
// Scoreboard bench for gf_vme_access_ctrl: a driver issues VME cycles and queues expectations,
// a monitor checks access rise, termination kind/latency/data and release.
module tb_gf_vme_access_ctrl;

  localparam logic [7:0] Base = 8'h20;
  localparam int SyncStages = 2;
  localparam int WrHold = 3;
  localparam int RdTimeout = 8;
  localparam int TAck = 0;
  localparam int TBerr = 1;
  localparam int TAbort = 2;

  logic        clk;
  logic        init_n;
  logic        vme_as_n, vme_ds_n, vme_write_n;
  logic [23:0] vme_addr;
  logic [31:0] vme_data_in;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [15:0] address;
  logic [31:0] wr_data;
  logic        writeAccess, readAccess;
  logic [31:0] vme_data_out;
  logic        data_oe, dtack_n, berr_n;

  gf_vme_access_ctrl #(
    .BASE_ADDR  (Base),
    .SYNC_STAGES(SyncStages),
    .WR_HOLD    (WrHold),
    .RD_TIMEOUT (RdTimeout)
  ) dut (
    .clk         (clk),
    .init_n      (init_n),
    .vme_as_n    (vme_as_n),
    .vme_ds_n    (vme_ds_n),
    .vme_write_n (vme_write_n),
    .vme_addr    (vme_addr),
    .vme_data_in (vme_data_in),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .address     (address),
    .wr_data     (wr_data),
    .writeAccess (writeAccess),
    .readAccess  (readAccess),
    .vme_data_out(vme_data_out),
    .data_oe     (data_oe),
    .dtack_n     (dtack_n),
    .berr_n      (berr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    int          term;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: data accepted the edge after rd_valid appears, unless the timeout edge came first.
  function automatic exp_t model_read(logic [15:0] a, logic [31:0] rdat, int d);
    exp_t e;
    e.is_write = 1'b0;
    e.addr     = a;
    e.wdata    = '0;
    e.rdata    = rdat;
    e.term     = (d < RdTimeout) ? TAck : TBerr;
    e.lat      = (d < RdTimeout) ? d + 1 : RdTimeout;
    return e;
  endfunction

  // Monitor
  logic prev_acc = 1'b0, prev_dt = 1'b1, prev_be = 1'b1, prev_ds = 1'b1;
  bit   in_cyc = 1'b0, term_seen = 1'b0;
  int   rise_cyc = 0, ds_rise_cyc = 0;
  exp_t cur;

  always @(posedge clk) begin
    logic acc;
    #1;
    cyc++;
    acc = readAccess | writeAccess;
    if (!init_n) begin
      in_cyc    = 1'b0;
      term_seen = 1'b0;
    end else begin
      check("excl_access", 32'(readAccess & writeAccess), 32'd0);
      check("excl_term", 32'(!dtack_n & !berr_n), 32'd0);
      if (vme_ds_n && !prev_ds) ds_rise_cyc = cyc;
      if (acc && !prev_acc) begin
        if (sb.size() == 0) begin
          check("unexpected_access", 32'(acc), 32'd0);
        end else begin
          cur       = sb[0];
          in_cyc    = 1'b1;
          term_seen = 1'b0;
          rise_cyc  = cyc;
          check("access_is_write", 32'(writeAccess), 32'(cur.is_write));
          check("address", 32'(address), 32'(cur.addr));
          if (cur.is_write) check("wr_data", wr_data, cur.wdata);
        end
      end
      if ((!dtack_n && prev_dt) || (!berr_n && prev_be)) begin
        if (!in_cyc || sb.size() == 0) begin
          check("unexpected_term", {dtack_n, berr_n}, 32'd3);
        end else begin
          cur       = sb.pop_front();
          term_seen = 1'b1;
          check("term_kind", 32'(!berr_n ? TBerr : TAck), 32'(cur.term));
          check("term_latency", 32'(cyc - rise_cyc), 32'(cur.lat));
          check("access_held", 32'(acc), 32'd1);
          if (cur.term == TAck && !cur.is_write) begin
            check("rd_data_out", vme_data_out, cur.rdata);
            check("data_oe_rd", 32'(data_oe), 32'd1);
          end else begin
            check("data_oe_off", 32'(data_oe), 32'd0);
          end
        end
      end
      if (!acc && prev_acc && in_cyc) begin
        if (!term_seen) begin
          if (sb.size() == 0) begin
            check("unexpected_drop", 32'(acc), 32'd1);
          end else begin
            cur = sb.pop_front();
            check("abort_kind", 32'(cur.term), 32'(TAbort));
          end
        end else begin
          check("release_lines", {data_oe, dtack_n, berr_n}, 32'b011);
          check("release_delay", 32'((cyc - ds_rise_cyc) <= SyncStages + 1), 32'd1);
        end
        in_cyc = 1'b0;
      end
    end
    prev_acc = acc;
    prev_dt  = dtack_n;
    prev_be  = berr_n;
    prev_ds  = vme_ds_n;
  end

  // Driver
  task automatic idle(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic start(logic [23:0] a, bit wr, logic [31:0] d);
    @(negedge clk);
    vme_addr    = a;
    vme_data_in = d;
    vme_write_n = !wr;
    vme_as_n    = 1'b0;
    vme_ds_n    = 1'b0;
  endtask

  task automatic finish_cycle();
    @(negedge clk);
    vme_as_n    = 1'b1;
    vme_ds_n    = 1'b1;
    vme_write_n = 1'b1;
    rd_valid    = 1'b0;
    idle(6);
  endtask

  task automatic wait_access(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (readAccess || writeAccess) begin
        ok = 1'b1;
        break;
      end
    end
    check("access_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_term();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!dtack_n || !berr_n) begin
        ok = 1'b1;
        break;
      end
    end
    check("term_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_write(logic [15:0] a, logic [31:0] d);
    exp_t e;
    e.is_write = 1'b1;
    e.term     = TAck;
    e.addr     = a;
    e.wdata    = d;
    e.rdata    = '0;
    e.lat      = WrHold;
    sb.push_back(e);
    start({Base, a}, 1'b1, d);
    wait_term();
    finish_cycle();
  endtask

  task automatic do_read(logic [15:0] a, logic [31:0] rdat, int d, bit reset_in_ack);
    bit ok;
    sb.push_back(model_read(a, rdat, d));
    start({Base, a}, 1'b0, $urandom);
    wait_access(ok);
    if (ok && d < RdTimeout) begin
      repeat (d) begin
        @(posedge clk);
        #1;
      end
      rd_data  = rdat;
      rd_valid = 1'b1;
    end
    wait_term();
    if (reset_in_ack) begin
      @(negedge clk);
      init_n   = 1'b0;
      vme_as_n = 1'b1;
      vme_ds_n = 1'b1;
      rd_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ack_dtack", 32'(dtack_n), 32'd1);
      check("rst_ack_read", 32'(readAccess), 32'd0);
      check("rst_ack_oe_berr", {data_oe, berr_n}, 32'b01);
      @(negedge clk);
      init_n = 1'b1;
    end
    finish_cycle();
  endtask

  task automatic do_unsel(logic [23:0] a, bit wr);
    start(a, wr, $urandom);
    idle(10);
    finish_cycle();
  endtask

  task automatic do_abort(logic [15:0] a);
    exp_t e;
    bit ok;
    e.is_write = 1'b0;
    e.term     = TAbort;
    e.addr     = a;
    e.wdata    = '0;
    e.rdata    = '0;
    e.lat      = 0;
    sb.push_back(e);
    start({Base, a}, 1'b0, 32'h0);
    wait_access(ok);
    idle(2);
    finish_cycle();
    check("abort_no_term", {dtack_n, berr_n}, 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] top;
    int kind;
    init_n      = 1'b0;
    vme_as_n    = 1'b1;
    vme_ds_n    = 1'b1;
    vme_write_n = 1'b1;
    vme_addr    = '0;
    vme_data_in = '0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_address", 32'(address), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_data_out", vme_data_out, 32'd0);
    check("rst_access", {writeAccess, readAccess}, 32'd0);
    check("rst_oe", 32'(data_oe), 32'd0);
    check("rst_dtack_berr", {dtack_n, berr_n}, 32'd3);
    @(negedge clk);
    init_n = 1'b1;
    idle(4);

    do_write(16'h0104, 32'hDEADBEEF);
    do_read(16'h0200, 32'h12345678, 3, 1'b0);
    do_read(16'h0300, 32'h0, 1000, 1'b0);
    do_unsel(24'h300000, 1'b1);
    do_write(16'h0008, 32'hCAFEF00D);
    do_abort(16'h0410);
    do_read(16'h0500, 32'hA5A5_5A5A, RdTimeout - 1, 1'b0);
    do_read(16'h0600, 32'h0BADCAFE, 1, 1'b1);
    do_read(16'h0700, 32'h7777_0001, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_write(16'($urandom), $urandom);
        1: do_read(16'($urandom), $urandom, $urandom_range(0, 10), 1'b0);
        2: begin
          top = 8'($urandom);
          if (top == Base) top = top ^ 8'h01;
          do_unsel({top, 16'($urandom)}, 1'($urandom));
        end
        default: do_abort(16'($urandom));
      endcase
    end

    idle(10);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
